mem_port_arbiter: RTL and testbench

- Shares the single-port 64-bit on-chip RAM model between NUM_REQ requesters, e.g. DMA read engine, DMA write engine and CPU-side config loader.
- Round-robin arbitration with bounded burst stickiness, a registered request stage toward memory, read-response routing back to the issuing requester, and an address-window check.
- Sits directly in front of the RAM's mem_wr_en/mem_waddr/mem_wdata/mem_wstrb/mem_rd_en/mem_raddr/mem_rdata interface. That memory returns read data exactly one cycle after rd_en.

---
 rtl/mem_port_arbiter.sv | 117 +++++++++++
 tb/tb_mem_port_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter with bounded burst stickiness in front of a single-port RAM.
// Requests are registered one stage toward memory; read responses return two cycles after accept.
module mem_port_arbiter #(
    parameter int                    NUM_REQ        = 2,
    parameter int                    DATA_WIDTH     = 64,
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int                    MAX_BURST      = 4,
    parameter logic [ADDR_WIDTH-1:0] MEM_START_ADDR = 32'h0000_0000,
    parameter logic [ADDR_WIDTH-1:0] MEM_END_ADDR   = 32'h0000_FFFF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ-1:0]            req_we_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
    input  logic [NUM_REQ*STRB_WIDTH-1:0] req_wstrb_i,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    output logic                          rsp_err_o,
    output logic [DATA_WIDTH-1:0]         rsp_rdata_o,
    output logic                          mem_wr_en_o,
    output logic [ADDR_WIDTH-1:0]         mem_waddr_o,
    output logic [DATA_WIDTH-1:0]         mem_wdata_o,
    output logic [STRB_WIDTH-1:0]         mem_wstrb_o,
    output logic                          mem_rd_en_o,
    output logic [ADDR_WIDTH-1:0]         mem_raddr_o,
    input  logic [DATA_WIDTH-1:0]         mem_rdata_i
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    logic [IW-1:0]         rr_ptr_q, rr_ptr_d, owner_q, owner_d, win, idx;
    logic                  owner_vld_q, owner_vld_d;
    logic [BW-1:0]         beat_q, beat_d;
    logic                  any_vld, sticky, found, hs_we, hs_legal;
    logic [ADDR_WIDTH-1:0] hs_addr, addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic                  wr_en_q, rd_en_q;
    logic                  s1_rd_q, s1_err_q, s2_rd_q, s2_err_q;
    logic [IW-1:0]         s1_id_q, s2_id_q;

    always_comb begin
        any_vld = |req_valid_i;
        sticky  = owner_vld_q && req_valid_i[owner_q] && (beat_q < BW'(MAX_BURST));
        found   = sticky;
        win     = owner_q;
        idx     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IW'((32'(rr_ptr_q) + i) % NUM_REQ);
            if (!found && req_valid_i[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        owner_vld_d = any_vld;
        owner_d     = any_vld ? win : owner_q;
        // a scan grant (new owner or re-grant after a full burst) always starts a fresh burst
        beat_d      = !any_vld ? '0 : sticky ? beat_q + 1'b1 : BW'(1);
        rr_ptr_d    = !any_vld ? rr_ptr_q : (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        hs_we       = req_we_i[win];
        hs_addr     = req_addr_i[win*ADDR_WIDTH +: ADDR_WIDTH];
        // offset compare handles any window, including one starting at address zero
        hs_legal    = (hs_addr - MEM_START_ADDR) <= (MEM_END_ADDR - MEM_START_ADDR);
    end

    assign req_ready_o = (rst_n && any_vld) ? (NUM_REQ'(1) << win) : '0;
    assign mem_wr_en_o = wr_en_q;
    assign mem_rd_en_o = rd_en_q;
    assign mem_waddr_o = addr_q;
    assign mem_raddr_o = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_wstrb_o = wstrb_q;
    assign rsp_valid_o = s2_rd_q ? (NUM_REQ'(1) << s2_id_q) : '0;
    assign rsp_err_o   = s2_rd_q && s2_err_q;
    assign rsp_rdata_o = (s2_rd_q && !s2_err_q) ? mem_rdata_i : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
            beat_q      <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            s1_rd_q     <= 1'b0;
            s1_err_q    <= 1'b0;
            s1_id_q     <= '0;
            s2_rd_q     <= 1'b0;
            s2_err_q    <= 1'b0;
            s2_id_q     <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
            beat_q      <= beat_d;
            wr_en_q     <= any_vld && hs_we && hs_legal;
            rd_en_q     <= any_vld && !hs_we && hs_legal;
            if (any_vld) begin
                addr_q  <= hs_addr;
                wdata_q <= req_wdata_i[win*DATA_WIDTH +: DATA_WIDTH];
                wstrb_q <= req_wstrb_i[win*STRB_WIDTH +: STRB_WIDTH];
            end
            s1_rd_q     <= any_vld && !hs_we;
            s1_err_q    <= !hs_legal;
            s1_id_q     <= win;
            s2_rd_q     <= s1_rd_q;
            s2_err_q    <= s1_err_q;
            s2_id_q     <= s1_id_q;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of grant order, memory-side timing and read responses.
module tb_mem_port_arbiter;
    localparam int N = 2, DW = 64, AW = 32, SW = 8;

    logic            clk = 1'b0, rst_n = 1'b0;
    logic [N-1:0]    req_valid, req_ready, req_we, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N*SW-1:0] req_wstrb;
    logic            rsp_err, mem_wr_en, mem_rd_en;
    logic [DW-1:0]   rsp_rdata, mem_wdata, mem_rdata = '0;
    logic [AW-1:0]   mem_waddr, mem_raddr;
    logic [SW-1:0]   mem_wstrb;
    logic [DW-1:0]   ram [16] = '{2: 64'hDEAD_BEEF_0123_4567, default: '0};
    logic [DW-1:0]   wtmp;
    logic [N-1:0]    exp_g [9] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    int              vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
        .rsp_valid_o(rsp_valid), .rsp_err_o(rsp_err), .rsp_rdata_o(rsp_rdata),
        .mem_wr_en_o(mem_wr_en), .mem_waddr_o(mem_waddr), .mem_wdata_o(mem_wdata),
        .mem_wstrb_o(mem_wstrb), .mem_rd_en_o(mem_rd_en), .mem_raddr_o(mem_raddr),
        .mem_rdata_i(mem_rdata)
    );

    // single-port RAM model with one-cycle read latency
    always @(posedge clk) begin
        if (mem_wr_en) begin
            wtmp = ram[mem_waddr[6:3]];
            for (int b = 0; b < SW; b++)
                if (mem_wstrb[b]) wtmp[b*8 +: 8] = mem_wdata[b*8 +: 8];
            ram[mem_waddr[6:3]] <= wtmp;
        end
        if (mem_rd_en) mem_rdata <= ram[mem_raddr[6:3]];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] s);
        req_we[k]            = we;
        req_addr[k*AW +: AW] = a;
        req_wdata[k*DW +: DW] = d;
        req_wstrb[k*SW +: SW] = s;
    endtask

    initial begin
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rd_en", mem_rd_en, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        rst_n = 1'b1;

        // single read by req1
        step(); set_req(1, 0, 32'h10, 0, 0); req_valid = 2'b10; #1;
        chk("rd_ready", req_ready, 2'b10);
        step(); req_valid = 2'b00; #1;
        chk("rd_mem_rd_en", mem_rd_en, 1);
        chk("rd_mem_raddr", mem_raddr, 32'h10);
        chk("rd_mem_wr_en", mem_wr_en, 0);
        chk("rd_no_early_rsp", rsp_valid, 0);
        step(); #1;
        chk("rd_rsp_valid", rsp_valid, 2'b10);
        chk("rd_rsp_rdata", rsp_rdata, 64'hDEAD_BEEF_0123_4567);
        chk("rd_rsp_err", rsp_err, 0);
        step(); #1;
        chk("rd_rsp_done", rsp_valid, 0);
        chk("rd_rdata_idle", rsp_rdata, 0);

        // partial write then read-back by req0
        step(); set_req(0, 1, 32'h8, 64'h1122_3344_5566_7788, 8'h0F); req_valid = 2'b01; #1;
        chk("wr_ready", req_ready, 2'b01);
        step(); set_req(0, 0, 32'h8, 0, 0); #1;
        chk("rb_ready", req_ready, 2'b01);
        chk("wr_mem_wr_en", mem_wr_en, 1);
        chk("wr_mem_rd_en", mem_rd_en, 0);
        chk("wr_waddr", mem_waddr, 32'h8);
        chk("wr_wdata", mem_wdata, 64'h1122_3344_5566_7788);
        chk("wr_wstrb", mem_wstrb, 8'h0F);
        step(); req_valid = 2'b00; #1;
        chk("rb_mem_rd_en", mem_rd_en, 1);
        chk("rb_mem_wr_en", mem_wr_en, 0);
        chk("rb_raddr", mem_raddr, 32'h8);
        chk("wr_no_rsp", rsp_valid, 0);
        step(); #1;
        chk("rb_rsp_valid", rsp_valid, 2'b01);
        chk("rb_rsp_rdata", rsp_rdata, 64'h0000_0000_5566_7788);
        chk("rb_rsp_err", rsp_err, 0);

        // out-of-window write then read by req1
        step(); set_req(1, 1, 32'h0001_0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF); req_valid = 2'b10; #1;
        chk("oor_wr_ready", req_ready, 2'b10);
        step(); set_req(1, 0, 32'h0001_0000, 0, 0); #1;
        chk("oor_rd_ready", req_ready, 2'b10);
        chk("oor_wr_no_wr_en", mem_wr_en, 0);
        chk("oor_wr_no_rd_en", mem_rd_en, 0);
        step(); req_valid = 2'b00; #1;
        chk("oor_rd_no_rd_en", mem_rd_en, 0);
        chk("oor_rd_no_wr_en", mem_wr_en, 0);
        chk("oor_wr_no_rsp", rsp_valid, 0);
        step(); #1;
        chk("oor_rsp_valid", rsp_valid, 2'b10);
        chk("oor_rsp_err", rsp_err, 1);
        chk("oor_rsp_rdata", rsp_rdata, 0);
        step(); #1;
        chk("oor_err_idle", rsp_err, 0);

        // burst fairness with both requesters continuously valid
        step(); set_req(0, 0, 32'h10, 0, 0); set_req(1, 0, 32'h20, 0, 0); req_valid = 2'b11;
        for (int i = 0; i < 9; i++) begin
            #1;
            chk($sformatf("burst_grant%0d", i), req_ready, exp_g[i]);
            step();
        end
        req_valid = 2'b00;

        // lone requester: a grant every cycle, past the burst limit
        step(); req_valid = 2'b01;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("lone_grant%0d", i), req_ready, 2'b01);
            if (i > 0) chk($sformatf("lone_rd_en%0d", i), mem_rd_en, 1);
            step();
        end
        req_valid = 2'b00;
        repeat (3) step();

        // reset asserted while a read is in flight
        set_req(1, 0, 32'h10, 0, 0); req_valid = 2'b10; #1;
        chk("rst_rd_ready", req_ready, 2'b10);
        step(); req_valid = 2'b11; #1;
        chk("rst_pre_rd_en", mem_rd_en, 1);
        rst_n = 1'b0; #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_raddr", mem_raddr, 0);
        chk("rst_wr_en", mem_wr_en, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        step(); #1;
        chk("rst_hold_rsp", rsp_valid, 0);
        step(); rst_n = 1'b1; #1;
        chk("rel_first_grant", req_ready, 2'b01);
        step(); req_valid = 2'b00; #1;
        chk("rel_no_rsp", rsp_valid, 0);
        chk("rel_rd_en", mem_rd_en, 1);
        step(); #1;
        chk("rel_rsp_valid", rsp_valid, 2'b01);
        chk("rel_rsp_rdata", rsp_rdata, 64'hDEAD_BEEF_0123_4567);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
